ifetch_queue: RTL
=================

# ifetch_queue

Parametrised instruction-fetch front end that replaces the single-register PC stage. Owns the fetch PC, issues requests to instruction memory through a valid/ready handshake, tracks in-flight requests, and buffers returned instructions with their PC in a DEPTH-entry queue feeding decode. A redirect from execute/branch resolution flushes the queue, discards in-flight responses, and restarts fetch at the redirect target.

## Interface

Parameters:

- DATA_WIDTH, 32, address and instruction width (`DATA_WIDTH`)
- RESET_PC, 32'h0000_0000, fetch address after reset
- DEPTH, 4, fetch queue entries; power of two, ≥2; also bounds outstanding requests

Ports:

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush and restart fetch
- redirect_addr  in  DATA_WIDTH  new fetch PC; bits [1:0] ignored (forced 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  DATA_WIDTH  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in order; no backpressure
- imem_rsp_data  in  DATA_WIDTH  instruction word
- out_valid  out  1  queue head valid
- out_ready  in  1  decode consumes head
- out_pc  out  DATA_WIDTH  PC of head instruction
- out_pc_plus4  out  DATA_WIDTH  out_pc + 4, modulo 2^DATA_WIDTH
- out_instr  out  DATA_WIDTH  head instruction word

## Operation

- State: fetch_pc, rsp_pc (PC of next expected response), inflight counter (0..DEPTH), drop counter (0..DEPTH), queue with count.
- Credit: imem_req_valid = (count + inflight < DEPTH). Guarantees every accepted response has a queue slot; response path has no ready.
- Request fire (valid & ready): fetch_pc += 4; inflight += 1.
- Response: inflight -= 1. If drop > 0: drop -= 1, data discarded, rsp_pc unchanged. Otherwise: enqueue {rsp_pc, data}, rsp_pc += 4.
- Dequeue on out_valid & out_ready.
- Redirect (takes priority over all else in that cycle): queue emptied; fetch_pc and rsp_pc ← {redirect_addr[DW-1:2], 2'b00}; drop ← inflight_next (counts any request firing and excludes any response arriving in the redirect cycle); a response arriving in the redirect cycle is discarded; a dequeue in the same cycle is still a valid consume by decode.
- Request handshake: imem_req_addr stable while valid & !ready, except the cycle after a redirect, where addr changes to the target.
- PC arithmetic wraps modulo 2^DATA_WIDTH.
- Back-to-back redirects: each reloads PCs; drop recomputed from current inflight.

## Timing

- Reset values: out_valid 0, imem_req_valid 0 during reset cycle, queue empty, inflight 0, drop 0, fetch_pc = rsp_pc = RESET_PC; out_pc/out_instr don't-care while out_valid 0.
- First request: cycle after rst deasserts, addr RESET_PC.
- Response enqueued at edge t appears as out_valid at t+1 (1-cycle registered queue; no rsp→out bypass).
- Redirect at cycle t: out_valid 0 at t+1; imem_req_addr = target at t+1 (valid if credit allows).
- Full throughput: with 1-cycle memory and out_ready held 1, one instruction per cycle steady state.
- Reset mid-operation: all state returns to reset values in one cycle; responses to pre-reset requests are the memory's responsibility to cancel.

## Structure

- `DATA_WIDTH` and `RESET_PC` constants live in Defines.vh.
- Sub-module sync_fifo (WIDTH = 2·DATA_WIDTH, DEPTH, flush input) holds {pc, instr}; counters and PC logic stay in ifetch_queue.
- Reuse existing MUX2 for fetch_pc next-value select.

## Test plan

- Reset, ready=1, 1-cycle memory returning addr as data, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles, out_instr = out_pc, out_pc_plus4 = out_pc+4.
- out_ready=0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid 0; count 4; release -> drains 0,4,8,12 then resumes at 16.
- imem_req_ready=0 for 3 cycles -> imem_req_addr held at same value; no fetch_pc advance.
- Memory latency 3, two requests in flight, redirect to 0x103 -> both stale responses dropped; next out_pc 0x100, next request addr 0x100.
- Redirect in same cycle as a request fire and a response arrival -> that response discarded, fired request later dropped, drop count correct; first out_pc is target.
- fetch_pc = 0xFFFF_FFFC -> next request addr 0x0, out_pc_plus4 of that entry 0x0.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared constants for the instruction-fetch front end
package ifetch_queue_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// rtl/ifetch_queue_sync_fifo.sv - synchronous FIFO with flush holding {pc, instr} entries
module ifetch_queue_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Writer never pushes when full: the owner reserves a slot for every request it issues.
  assign push     = wr_valid & ~flush;
  assign pop      = rd_ready & rd_valid & ~flush;
  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch PC owner, credit-limited imem requester and decode-side queue
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int                   DATA_WIDTH = ifetch_queue_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = ifetch_queue_pkg::RESET_PC,
  parameter int                   DEPTH      = ifetch_queue_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_addr,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_pc_plus4,
  output logic [DATA_WIDTH-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0]   fetch_pc;
  logic [DATA_WIDTH-1:0]   fetch_pc_next;
  logic [DATA_WIDTH-1:0]   rsp_pc;
  logic [DATA_WIDTH-1:0]   target;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           inflight_next;
  logic [CW-1:0]           drop;
  logic [CW-1:0]           count;
  logic [CW:0]             occupancy;
  logic                    req_fire;
  logic                    rsp_keep;
  logic [2*DATA_WIDTH-1:0] head;

  assign target    = {redirect_addr[DATA_WIDTH-1:2], 2'b00};
  assign occupancy = {1'b0, count} + {1'b0, inflight};

  // Every outstanding request owns a queue slot, so the response path never stalls.
  assign imem_req_valid = ~rst & (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_keep       = imem_rsp_valid & (drop == '0) & ~redirect_valid;
  assign inflight_next  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_next = target;
    end else if (req_fire) begin
      fetch_pc_next = fetch_pc + FOUR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      fetch_pc <= fetch_pc_next;
      inflight <= inflight_next;
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        rsp_pc <= target;
        drop   <= inflight_next;
      end else if (imem_rsp_valid) begin
        if (drop != '0) drop   <= drop - CW'(1);
        else            rsp_pc <= rsp_pc + FOUR;
      end
    end
  end

  ifetch_queue_sync_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .wr_valid (rsp_keep),
    .wr_data  ({rsp_pc, imem_rsp_data}),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (head),
    .count    (count)
  );

  assign out_pc       = head[2*DATA_WIDTH-1:DATA_WIDTH];
  assign out_instr    = head[DATA_WIDTH-1:0];
  assign out_pc_plus4 = out_pc + FOUR;

endmodule
